// File: rtl/seg7_mux_decoder.sv
// seg7_mux_decoder
// Watches the segment and digit-enable lines of a two-digit multiplexed
// 7-segment display. It recovers the BCD ones/tens digits being shown and
// reports valid, change (update) and illegal-glyph (bad_code) status.
//
// Pipeline from the pins to the outputs:
//   pins -> sync1_q -> s_q -> s_prev_q
//   s_q vs s_prev_q        : change detect, which drives the run counter
//   run counter + taken    : at most one capture per stable window
//   s_prev_q at capture    : the window value that is decoded and stored
//
// For pins that change before edge E0 and then hold, the registered
// outputs move at E(STABLE_CYCLES+2).
// STABLE_CYCLES must lie in 2..255, because the run counter is 8 bits.

module seg7_mux_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT_W     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic [1:0] dig,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       valid,
  output logic       update,
  output logic       bad_code
);

  // Run-count value at which a window has shown STABLE_CYCLES equal samples.
  localparam logic [7:0] RUN_TARGET = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] RUN_MAX    = 8'hFF;

  localparam logic [1:0] DIG_ONES = 2'b01;
  localparam logic [1:0] DIG_TENS = 2'b10;

  localparam logic [TIMEOUT_W-1:0] WD_LAST = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = TIMEOUT_W'(1);

  // One synchronised snapshot of the display pins.
  typedef struct packed {
    logic [1:0] dig;
    logic [6:0] seg;
  } sample_t;

  // Result of decoding one segment pattern.
  typedef struct packed {
    logic       legal;
    logic [3:0] digit;
  } glyph_t;

  // Map a segment pattern to a BCD digit. Only exact matches are legal.
  function automatic glyph_t decode_glyph(input logic [6:0] pattern);
    glyph_t g;
    g = '{legal: 1'b1, digit: 4'd0};
    case (pattern)
      7'h3F:   g.digit = 4'd0;
      7'h06:   g.digit = 4'd1;
      7'h5B:   g.digit = 4'd2;
      7'h4F:   g.digit = 4'd3;
      7'h66:   g.digit = 4'd4;
      7'h6D:   g.digit = 4'd5;
      7'h7D:   g.digit = 4'd6;
      7'h07:   g.digit = 4'd7;
      7'h7F:   g.digit = 4'd8;
      7'h6F:   g.digit = 4'd9;
      default: g = '{legal: 1'b0, digit: 4'd0};
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------------
  // Synchroniser and previous-sample register
  // ---------------------------------------------------------------------
  sample_t sync1_q;
  sample_t s_q;
  sample_t s_prev_q;

  // Two-flop synchroniser on the asynchronous pins, then a one-cycle
  // history of the synchronised sample.
  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the pre-edge values; a blocking assignment here would collapse
  // the chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      s_q      <= '0;
      s_prev_q <= '0;
    end else begin
      sync1_q  <= '{dig: dig, seg: seg};
      s_q      <= sync1_q;
      s_prev_q <= s_q;
    end
  end

  // A dig-only change counts as a change too, because the whole sample
  // is compared.
  logic change;
  assign change = (s_q != s_prev_q);

  // ---------------------------------------------------------------------
  // Stability window: run counter and one-capture-per-window flag
  // ---------------------------------------------------------------------
  logic [7:0] run_q;
  logic [7:0] run_d;
  logic       taken_q;
  logic       taken_d;
  logic       capture;
  logic       dig_legal;

  // The window value sits in s_prev_q. When run_q reaches RUN_TARGET,
  // s_prev_q has held it for STABLE_CYCLES synchronised samples.
  assign dig_legal = (s_prev_q.dig == DIG_ONES) || (s_prev_q.dig == DIG_TENS);
  assign capture   = !taken_q && (run_q == RUN_TARGET) && dig_legal;

  // Saturating run count, restarted on any change of the sample. The
  // taken flag is set by a capture and cleared when a new window opens.
  // NOTE: every combinational output gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    run_d   = run_q;
    taken_d = taken_q;
    if (change) begin
      run_d   = '0;
      taken_d = 1'b0;
    end else begin
      if (run_q != RUN_MAX) begin
        run_d = run_q + 8'd1;
      end
      if (capture) begin
        taken_d = 1'b1;
      end
    end
  end

  // Run counter and taken flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      taken_q <= taken_d;
    end
  end

  // ---------------------------------------------------------------------
  // Capture, digit storage, status flags and watchdog
  // ---------------------------------------------------------------------
  glyph_t glyph;
  assign glyph = decode_glyph(s_prev_q.seg);

  logic                 wr_ones;
  logic                 wr_tens;
  logic                 bad_set;
  logic                 wd_wrap;

  logic [3:0]           ones_q;
  logic [3:0]           ones_d;
  logic [3:0]           tens_q;
  logic [3:0]           tens_d;
  logic                 have_o_q;
  logic                 have_o_d;
  logic                 have_t_q;
  logic                 have_t_d;
  logic                 valid_q;
  logic                 valid_d;
  logic                 update_q;
  logic                 update_d;
  logic                 bad_q;
  logic                 bad_d;
  logic [TIMEOUT_W-1:0] wd_q;
  logic [TIMEOUT_W-1:0] wd_d;

  assign wr_ones = capture && glyph.legal && (s_prev_q.dig == DIG_ONES);
  assign wr_tens = capture && glyph.legal && (s_prev_q.dig == DIG_TENS);
  assign bad_set = capture && !glyph.legal;

  // A capture clears the watchdog, so the watchdog only wraps in a cycle
  // without one. That makes the capture the winner.
  assign wd_wrap = (wd_q == WD_LAST) && !capture;

  // Next-state logic for the stored digits, the have-flags, valid,
  // update, the sticky error flag and the watchdog.
  always_comb begin
    ones_d   = ones_q;
    tens_d   = tens_q;
    have_o_d = have_o_q;
    have_t_d = have_t_q;
    bad_d    = bad_q | bad_set;
    wd_d     = wd_q + WD_ONE;

    if (capture || wd_wrap) begin
      wd_d = '0;
    end

    if (wd_wrap) begin
      have_o_d = 1'b0;
      have_t_d = 1'b0;
    end

    if (wr_ones) begin
      ones_d   = glyph.digit;
      have_o_d = 1'b1;
    end
    if (wr_tens) begin
      tens_d   = glyph.digit;
      have_t_d = 1'b1;
    end

    valid_d = have_o_d & have_t_d;

    // A value change counts only against a digit that is already held.
    // Otherwise the reset or stale value would look like a change. The
    // rise of valid always pulses.
    update_d = (wr_ones && have_o_q && (glyph.digit != ones_q)) ||
               (wr_tens && have_t_q && (glyph.digit != tens_q)) ||
               (valid_d && !valid_q);
  end

  // Output-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q   <= '0;
      tens_q   <= '0;
      have_o_q <= 1'b0;
      have_t_q <= 1'b0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      bad_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      ones_q   <= ones_d;
      tens_q   <= tens_d;
      have_o_q <= have_o_d;
      have_t_q <= have_t_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      bad_q    <= bad_d;
      wd_q     <= wd_d;
    end
  end

  assign ones     = ones_q;
  assign tens     = tens_q;
  assign valid    = valid_q;
  assign update   = update_q;
  assign bad_code = bad_q;

endmodule
